// File: rtl/vga_bus_pkg.sv
// Shared definitions for the processor-to-VGA bus: peripheral register
// addresses, frame buffer limits (160x120) and the rectangle writer FSM states.
package vga_bus_pkg;
  localparam int          BUS_W         = 8;
  localparam logic [7:0]  VGA_BASE_ADDR = 8'hB0;
  localparam logic [7:0]  VGA_X_REG     = 8'hB1;
  localparam logic [7:0]  VGA_Y_REG     = 8'hB2;
  localparam int          FB_X_MAX      = 159;
  localparam int          FB_Y_MAX      = 119;

  typedef enum logic [2:0] {
    IDLE, REQ, ROW_Y, ROW_GAP, PIX_X, PIX_GAP, FIN
  } state_e;
endpackage

// File: rtl/vga_rect_clip.sv
// Combinational rectangle clipper.
//   x0/y0/width/height : requested rectangle
//   x_start..y_end     : inclusive bounds clipped to the frame buffer
//   empty              : nothing to draw (zero size or origin off-screen)
module vga_rect_clip
  import vga_bus_pkg::*;
#(
  parameter int X_MAX = FB_X_MAX,
  parameter int Y_MAX = FB_Y_MAX
) (
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] x_start,
  output logic [7:0] x_end,
  output logic [6:0] y_start,
  output logic [6:0] y_end,
  output logic       empty
);
  // 9 bits hold x0+width-1 (max 509) without wrap; underflow only when
  // width==0, which is already flagged empty.
  logic [8:0] x_last, y_last;

  assign x_last  = {1'b0, x0} + {1'b0, width} - 9'd1;
  assign y_last  = {2'b0, y0} + {2'b0, height} - 9'd1;
  assign x_start = x0;
  assign y_start = y0;
  assign x_end   = (x_last > 9'(X_MAX)) ? 8'(X_MAX) : x_last[7:0];
  assign y_end   = (y_last > 9'(Y_MAX)) ? 7'(Y_MAX) : y_last[6:0];
  assign empty   = (width == 8'd0) || (height == 7'd0) ||
                   ({1'b0, x0} > 9'(X_MAX)) || ({2'b0, y0} > 9'(Y_MAX));
endmodule

// File: rtl/vga_rect_writer.sv
// Bus initiator that fills a rectangle of the VGA frame buffer: per row it
// writes the Y register once, then the X register once per column; each
// coordinate write strobes one pixel. Arbitrates with BUS_REQ/BUS_GNT.
//   CLK, RESET_N        : clock, async active-low reset
//   START, X0..HEIGHT   : fill request, sampled in IDLE only
//   BUS_GNT / BUS_REQ   : arbiter handshake
//   BUS_ADDR/DATA/WE    : write port, address/data zero when not writing
//   BUSY, DONE          : in-progress flag, one-cycle completion pulse
module vga_rect_writer
  import vga_bus_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8,
  parameter logic [7:0] VGA_X_ADDR = VGA_X_REG,
  parameter logic [7:0] VGA_Y_ADDR = VGA_Y_REG,
  parameter int         X_MAX      = FB_X_MAX,
  parameter int         Y_MAX      = FB_Y_MAX
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        X0,
  input  logic [6:0]        Y0,
  input  logic [7:0]        WIDTH,
  input  logic [6:0]        HEIGHT,
  input  logic              BUS_GNT,
  output logic              BUS_REQ,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_DATA,
  output logic              BUS_WE,
  output logic              BUSY,
  output logic              DONE
);
  state_e            state_q, state_d;
  logic [7:0]        x_q, x_d, xs_q, xs_d, xe_q, xe_d;
  logic [6:0]        y_q, y_d, ye_q, ye_d;
  logic              req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [7:0] c_xs, c_xe;
  logic [6:0] c_ys, c_ye;
  logic       c_empty;

  vga_rect_clip #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_clip (
    .x0(X0), .y0(Y0), .width(WIDTH), .height(HEIGHT),
    .x_start(c_xs), .x_end(c_xe), .y_start(c_ys), .y_end(c_ye),
    .empty(c_empty)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    case (state_q)
      IDLE: if (START) begin
        xs_d    = c_xs;
        xe_d    = c_xe;
        ye_d    = c_ye;
        x_d     = c_xs;
        y_d     = c_ys;
        state_d = c_empty ? FIN : REQ;
      end
      REQ:     if (BUS_GNT) state_d = ROW_Y;
      // A write state is left only after its strobe went out; without
      // grant it holds with the bus idle and retries the same coordinate.
      ROW_Y:   if (we_q) state_d = ROW_GAP;
      ROW_GAP: begin
        x_d     = xs_q;
        state_d = PIX_X;
      end
      PIX_X:   if (we_q) state_d = PIX_GAP;
      PIX_GAP: begin
        if (x_q < xe_q) begin
          x_d     = x_q + 8'd1;
          state_d = PIX_X;
        end else if (y_q < ye_q) begin
          y_d     = y_q + 7'd1;
          state_d = ROW_Y;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with
  // it; grant is sampled at the edge that would launch a write.
  always_comb begin
    we_d   = ((state_d == ROW_Y) || (state_d == PIX_X)) && BUS_GNT;
    addr_d = '0;
    data_d = '0;
    if (we_d) begin
      if (state_d == ROW_Y) begin
        addr_d = ADDR_W'(VGA_Y_ADDR);
        data_d = DATA_W'({1'b0, y_d});
      end else begin
        addr_d = ADDR_W'(VGA_X_ADDR);
        data_d = DATA_W'(x_d);
      end
    end
    req_d  = (state_d != IDLE) && (state_d != FIN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign BUS_REQ  = req_q;
  assign BUS_WE   = we_q;
  assign BUS_ADDR = addr_q;
  assign BUS_DATA = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
endmodule

// File: tb/tb_vga_rect_writer.sv
// Scoreboard bench for vga_rect_writer: the stimulus pushes the expected
// write sequence of each directed fill; the monitor pops on every BUS_WE.
module tb_vga_rect_writer;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [7:0] X0 = '0;
  logic [6:0] Y0 = '0;
  logic [7:0] WIDTH = '0;
  logic [6:0] HEIGHT = '0;
  logic       BUS_GNT = 1'b1;
  logic       BUS_REQ, BUS_WE, BUSY, DONE;
  logic [7:0] BUS_ADDR, BUS_DATA;

  vga_rect_writer dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .X0(X0), .Y0(Y0),
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BUS_GNT(BUS_GNT), .BUS_REQ(BUS_REQ),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0, errors = 0;
  int cyc = 0, req_cyc = 0, done_cyc = 0, start_cyc = 0;
  int busy_cnt = 0, req_cnt = 0, done_cnt = 0, we_cnt = 0, xw_cnt = 0;
  logic we_prev = 1'b0, req_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        we_prev  = 1'b0;
        req_prev = 1'b0;
      end else begin
        cyc++;
        if (BUS_WE) begin
          we_cnt++;
          chk("we_needs_gnt", int'(BUS_GNT), 1);
          chk("we_followed_by_idle", int'(we_prev), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {BUS_ADDR, BUS_DATA}, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", BUS_ADDR, mon_e.a);
            chk("wr_data", BUS_DATA, mon_e.d);
          end
          if (BUS_ADDR == 8'hB1) xw_cnt++;
        end else begin
          chk("idle_bus_zero", {BUS_ADDR, BUS_DATA}, 0);
        end
        if (BUS_REQ && !req_prev) req_cyc = cyc;
        if (BUSY) busy_cnt++;
        if (BUS_REQ) req_cnt++;
        if (DONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
        we_prev  = BUS_WE;
        req_prev = BUS_REQ;
      end
    end
  end

  // START high for one cycle; sampled at the following rising edge.
  task automatic start_fill(input logic [7:0] x, input logic [6:0] y,
                            input logic [7:0] w, input logic [6:0] h);
    @(posedge CLK); #2;
    X0 = x; Y0 = y; WIDTH = w; HEIGHT = h;
    START = 1'b1;
    start_cyc = cyc;
    @(posedge CLK); #2;
    START = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget && done_cnt == n0; i++) @(posedge CLK);
    if (done_cnt == n0) chk("done_timeout", done_cnt, n0 + 1);
    repeat (3) @(posedge CLK);
    #2;
  endtask

  task automatic wait_xw(input int target, input int budget);
    for (int i = 0; i < budget && xw_cnt < target; i++) begin
      @(posedge CLK); #2;
    end
    if (xw_cnt < target) chk("xwrite_timeout", xw_cnt, target);
  endtask

  int d0, b0, r0, w0;

  initial begin
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_outputs", {BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE}, 0);
    RESET_N = 1'b1;

    // Basic 2x2 fill, grant tied high.
    d0 = done_cnt; b0 = busy_cnt; r0 = req_cnt;
    push(8'hB2, 8'h05); push(8'hB1, 8'h0A); push(8'hB1, 8'h0B);
    push(8'hB2, 8'h06); push(8'hB1, 8'h0A); push(8'hB1, 8'h0B);
    start_fill(8'd10, 7'd5, 8'd2, 7'd2);
    wait_done(d0, 100);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_req_latency", req_cyc - start_cyc, 2);
    chk("t1_done_latency", done_cyc - req_cyc, 13);
    chk("t1_busy_cycles", busy_cnt - b0, 14);
    chk("t1_req_cycles", req_cnt - r0, 13);
    chk("t1_done_count", done_cnt - d0, 1);

    // Clipped at the bottom-right corner.
    d0 = done_cnt; b0 = busy_cnt;
    push(8'hB2, 8'h77); push(8'hB1, 8'h9E); push(8'hB1, 8'h9F);
    start_fill(8'd158, 7'd119, 8'd4, 7'd3);
    wait_done(d0, 100);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_done_latency", done_cyc - req_cyc, 7);
    chk("t2_busy_cycles", busy_cnt - b0, 8);
    chk("t2_done_count", done_cnt - d0, 1);

    // Degenerate: zero width, then origin off-screen.
    d0 = done_cnt; b0 = busy_cnt; r0 = req_cnt; w0 = we_cnt;
    start_fill(8'd10, 7'd5, 8'd0, 7'd2);
    wait_done(d0, 20);
    chk("t3a_done_latency", done_cyc - start_cyc, 2);
    chk("t3a_busy_cycles", busy_cnt - b0, 1);
    chk("t3a_req_cycles", req_cnt - r0, 0);
    chk("t3a_writes", we_cnt - w0, 0);
    d0 = done_cnt; b0 = busy_cnt; r0 = req_cnt; w0 = we_cnt;
    start_fill(8'd200, 7'd5, 8'd5, 7'd5);
    wait_done(d0, 20);
    chk("t3b_done_latency", done_cyc - start_cyc, 2);
    chk("t3b_busy_cycles", busy_cnt - b0, 1);
    chk("t3b_req_cycles", req_cnt - r0, 0);
    chk("t3b_writes", we_cnt - w0, 0);

    // 3x1 fill with grant removed for five cycles after the second column.
    d0 = done_cnt;
    push(8'hB2, 8'h00); push(8'hB1, 8'h00); push(8'hB1, 8'h01); push(8'hB1, 8'h02);
    w0 = xw_cnt;
    start_fill(8'd0, 7'd0, 8'd3, 7'd1);
    wait_xw(w0 + 1, 50);
    repeat (2) @(posedge CLK);
    #2;
    BUS_GNT = 1'b0;
    w0 = we_cnt;
    repeat (5) @(posedge CLK);
    #2;
    chk("t4_no_we_without_gnt", we_cnt - w0, 0);
    chk("t4_req_held", int'(BUS_REQ), 1);
    BUS_GNT = 1'b1;
    wait_done(d0, 100);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_done_count", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a row.
    push(8'hB2, 8'h1E); push(8'hB1, 8'h14); push(8'hB1, 8'h15);
    push(8'hB1, 8'h16); push(8'hB1, 8'h17);
    w0 = xw_cnt;
    start_fill(8'd20, 7'd30, 8'd4, 7'd2);
    wait_xw(w0 + 2, 50);
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("t5_async_reset_outputs", {BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE}, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #2;
    chk("t5_reset_held_outputs", {BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE}, 0);
    RESET_N = 1'b1;
    d0 = done_cnt;
    push(8'hB2, 8'h02); push(8'hB1, 8'h01); push(8'hB1, 8'h02);
    start_fill(8'd1, 7'd2, 8'd2, 7'd1);
    wait_done(d0, 100);
    chk("t5_queue_empty", exp_q.size(), 0);
    chk("t5_done_latency", done_cyc - req_cyc, 7);

    // Second START while busy with other coordinates is ignored.
    d0 = done_cnt;
    push(8'hB2, 8'h06); push(8'hB1, 8'h05); push(8'hB1, 8'h06);
    start_fill(8'd5, 7'd6, 8'd2, 7'd1);
    repeat (2) @(posedge CLK);
    #2;
    X0 = 8'd50; Y0 = 7'd60; WIDTH = 8'd3; HEIGHT = 7'd3;
    START = 1'b1;
    @(posedge CLK); #2;
    START = 1'b0;
    wait_done(d0, 100);
    repeat (20) @(posedge CLK);
    #2;
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_done_latency", done_cyc - req_cyc, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_rect_writer.md
# vga_rect_writer

Bus-initiator block that fills an axis-aligned rectangle in the VGA frame buffer by issuing write transactions to the VGA peripheral's X (0xB1) and Y (0xB2) coordinate registers; every coordinate write strobes one pixel into the buffer. It is the writer end of the processor-to-VGA bus: it arbitrates for the shared 8-bit bus with a request/grant pair, so the microprocessor can offload screen fills. The frame buffer is 160×120: X is 8 bits, Y is 7 bits.

## Interface
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width
- VGA_X_ADDR, 8'hB1, X coordinate register address
- VGA_Y_ADDR, 8'hB2, Y coordinate register address
- X_MAX, 159, last valid column
- Y_MAX, 119, last valid row

- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request to begin a fill
- X0  in  8  left column
- Y0  in  7  top row
- WIDTH  in  8  columns to fill
- HEIGHT  in  7  rows to fill
- BUS_GNT  in  1  bus grant from arbiter
- BUS_REQ  out  1  bus request
- BUS_ADDR  out  ADDR_W  write address, 0 when not writing
- BUS_DATA  out  DATA_W  write data, 0 when not writing
- BUS_WE  out  1  write strobe
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, REQ, ROW_Y, ROW_GAP, PIX_X, PIX_GAP, FIN.
- IDLE: START=1 latches X0, Y0, WIDTH, HEIGHT; computes x_end = min(X0+WIDTH-1, X_MAX), y_end = min(Y0+HEIGHT-1, Y_MAX) in 9-bit arithmetic. WIDTH=0, HEIGHT=0, X0>X_MAX or Y0>Y_MAX → FIN directly, no bus request. Otherwise → REQ.
- REQ: BUS_REQ=1; BUS_GNT=1 → ROW_Y.
- ROW_Y: one-cycle write, BUS_ADDR=VGA_Y_ADDR, BUS_DATA={1'b0,y}; → ROW_GAP (bus idle) → PIX_X with x=x_start.
- PIX_X: one-cycle write, BUS_ADDR=VGA_X_ADDR, BUS_DATA=x; → PIX_GAP. PIX_GAP: x<x_end → x+1, PIX_X; else y<y_end → y+1, ROW_Y; else → FIN.
- FIN: DONE=1 one cycle, BUS_REQ drops, → IDLE.
- BUS_REQ held high from REQ through last PIX_GAP.
- Grant loss: BUS_WE never asserted while BUS_GNT=0. If BUS_GNT=0 on entry to ROW_Y or PIX_X, the FSM stalls there, outputs zero, then issues the same write once grant returns; no coordinate skipped or repeated.
- START while BUSY ignored; inputs changing while BUSY ignored.
- Reset (any time): state IDLE, all outputs 0 immediately, counters cleared.

## Timing
- Reset values: BUS_REQ=0, BUS_ADDR=0, BUS_DATA=0, BUS_WE=0, BUSY=0, DONE=0.
- All outputs registered.
- START at edge n → BUS_REQ and BUSY high after edge n+1.
- Grant constant high: fill of W×H clipped pixels takes 1 + H·(2+2W) cycles after REQ entry, then 1 DONE cycle.
- Degenerate fill: DONE pulses the cycle after START; BUSY high only that DONE cycle.
- Every write is one BUS_WE cycle followed by at least one idle cycle.

## Structure
- Shared package vga_bus_pkg: VGA base/X/Y address constants, X_MAX/Y_MAX, FSM state enum.
- Sub-module vga_rect_clip: combinational clip/degenerate detection producing x_start, x_end, y_start, y_end, empty.

## Test plan
- X0=10, Y0=5, W=2, H=2, grant tied high → writes B2:05, B1:0A, B1:0B, B2:06, B1:0A, B1:0B, each followed by an idle cycle; DONE 13 cycles after REQ entry.
- X0=158, Y0=119, W=4, H=3 → clipped to B2:77, B1:9E, B1:9F only; DONE once.
- W=0 (and separately X0=200) → no BUS_REQ, no BUS_WE, DONE the cycle after START.
- 3×1 fill, BUS_GNT dropped 4 cycles after first X write, restored 5 cycles later → BUS_WE stays 0 while low; X sequence exactly 0,1,2 with none repeated.
- RESET_N low mid-row → all outputs 0 without a clock edge; after release, new START produces a full correct fill.
- START pulsed again while BUSY with different coordinates → ignored; only the first rectangle written.
